lcd_bus_arbiter: RTL and testbench

Shares the single Avalon-MM slave port of the LCD_Controller between N_REQ independent message sources, e.g. a menu-text writer and a status/score writer. Each requester offers 9-bit LCD instruction words over a valid/ready handshake. The block grants the bus round-robin, latches the accepted word and drives one Avalon write per word, honouring `waitrequest`. A requester can hold the bus across a multi-word message (CLEAR_DISPLAY plus characters) with a lock line, so messages never interleave on the display.

---
 rtl/lcd_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
//   Shares the single Avalon-MM slave port of the LCD controller between
//   N_REQ message sources. Each accepted 9-bit word becomes one Avalon write.
//   The bus is granted round-robin. With LCD_ARB_LOCK_EN defined, a requester
//   can hold the bus across a multi-word message using req_lock.
//
//   Build option: LCD_ARB_LOCK_EN (undefined by default, req_lock ignored)
//
//   Ports
//     clk, reset_n      system clock, asynchronous active-low reset
//     req_valid/ready   per-requester handshake (req_ready is combinational)
//     req_data          9 bits per requester: [8] = LCD address, [7:0] = data
//     req_lock          keep the grant after the current word
//     req_done          one-cycle pulse when a requester's word completes
//     grant             one-hot owner while in WRITE/LOCKED
//     address, chipselect, byteenable, read, write, writedata,
//     waitrequest, readdata, response   Avalon-MM master side
//
//   state  | meaning
//   IDLE   | no owner; round-robin search from ptr for a valid requester
//   WRITE  | Avalon write of the latched word, held while waitrequest=1
//   LOCKED | owner keeps the bus between words of one message
module lcd_bus_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [9*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   grant,
  output logic               address,
  output logic               chipselect,
  output logic               byteenable,
  output logic               read,
  output logic               write,
  output logic [7:0]         writedata,
  input  logic               waitrequest,
  input  logic [7:0]         readdata,
  input  logic [1:0]         response
);

  localparam int PW = $clog2(N_REQ);

`ifdef LCD_ARB_LOCK_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_LOCKED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1} state_t;
`endif

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [8:0]      word_q, word_d;

  logic [8:0]      req_word [N_REQ];
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   ptr_after_owner;

  // readdata/response carry nothing for a write-only master
`ifdef LCD_ARB_LOCK_EN
  logic unused_inputs;
  assign unused_inputs = ^{readdata, response};
`else
  logic unused_inputs;
  assign unused_inputs = ^{readdata, response, req_lock};
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[9*g +: 9];
  end

  // Walk offsets from high to low so the lowest offset from ptr wins last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign ptr_after_owner = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    word_d    = word_q;
    req_ready = '0;
    req_done  = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          req_ready[sel_idx] = 1'b1;
          word_d             = req_word[sel_idx];
          owner_d            = sel_idx;
          state_d            = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!waitrequest) begin
          req_done[owner_q] = 1'b1;
`ifdef LCD_ARB_LOCK_EN
          if (req_lock[owner_q]) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_IDLE;
            ptr_d   = ptr_after_owner;
          end
`else
          state_d = ST_IDLE;
          ptr_d   = ptr_after_owner;
`endif
        end
      end
`ifdef LCD_ARB_LOCK_EN
      ST_LOCKED: begin
        // A pending word wins over a falling lock: the message's last word
        // may arrive together with the lock release.
        if (req_valid[owner_q]) begin
          req_ready[owner_q] = 1'b1;
          word_d             = req_word[owner_q];
          state_d            = ST_WRITE;
        end else if (!req_lock[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_after_owner;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      word_q  <= word_d;
    end
  end

  assign write      = (state_q == ST_WRITE);
  assign chipselect = write;
  assign address    = write & word_q[8];
  assign writedata  = write ? word_q[7:0] : 8'h00;
  assign byteenable = 1'b1;
  assign read       = 1'b0;

  always_comb begin
    grant = '0;
    if (state_q != ST_IDLE) grant[owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
module tb_lcd_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [17:0] req_data;
  logic [1:0]  req_lock;
  logic [1:0]  req_ready, req_done, grant;
  logic        address, chipselect, byteenable, read, write;
  logic [7:0]  writedata;
  logic        waitrequest;
  logic [7:0]  readdata;
  logic [1:0]  response;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .req_done(req_done), .grant(grant),
    .address(address), .chipselect(chipselect), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata), .response(response)
  );

  typedef struct {
    logic [1:0] valid;
    logic [8:0] d0;
    logic [8:0] d1;
    logic       wr;
    logic [1:0] ready;
    logic [1:0] done;
    logic [1:0] gnt;
    logic       wrt;
    logic       addr;
    logic [7:0] wd;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [8:0] d0, input logic [8:0] d1,
                       input logic [1:0] lk, input logic wr);
    req_valid   = v;
    req_data    = {d1, d0};
    req_lock    = lk;
    waitrequest = wr;
  endtask

  initial begin
    int         n1;
    logic [1:0] exp_own;
    logic [7:0] exp_wd;

    //         valid  d0      d1      wr    ready  done   gnt    wrt   addr  wd
    tbl[0]  = '{2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{2'b01, 9'h101, 9'h000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1, 8'h01};
    tbl[3]  = '{2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{2'b01, 9'h0AB, 9'h000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{2'b01, 9'h1FF, 9'h000, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'hAB};
    tbl[6]  = '{2'b01, 9'h1FF, 9'h000, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'hAB};
    tbl[7]  = '{2'b00, 9'h000, 9'h000, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'hAB};
    tbl[8]  = '{2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 8'hAB};
    tbl[9]  = '{2'b11, 9'h010, 9'h120, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{2'b11, 9'h010, 9'h120, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 8'h20};
    tbl[11] = '{2'b11, 9'h010, 9'h120, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{2'b11, 9'h010, 9'h120, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 8'h10};
    tbl[13] = '{2'b11, 9'h010, 9'h120, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{2'b11, 9'h010, 9'h120, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 8'h20};
    tbl[15] = '{2'b10, 9'h000, 9'h133, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 8'h33};
    tbl[17] = '{2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};

    reset_n  = 1'b0;
    readdata = 8'h00;
    response = 2'b00;
    drive(2'b00, 9'h000, 9'h000, 2'b00, 1'b0);
    #3;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_cs", 32'(chipselect), 32'd0);
    chk("rst_wd", 32'(writedata), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_be", 32'(byteenable), 32'd1);
    chk("rst_read", 32'(read), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].valid, tbl[i].d0, tbl[i].d1, 2'b00, tbl[i].wr);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      chk($sformatf("v%0d_done", i), 32'(req_done), 32'(tbl[i].done));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_write", i), 32'(write), 32'(tbl[i].wrt));
      chk($sformatf("v%0d_cs", i), 32'(chipselect), 32'(tbl[i].wrt));
      chk($sformatf("v%0d_addr", i), 32'(address), 32'(tbl[i].addr));
      chk($sformatf("v%0d_wd", i), 32'(writedata), 32'(tbl[i].wd));
      cyc();
    end

    // Reset during a stalled write; ptr=1 beforehand so the recovery
    // grant to requester 0 shows ptr was cleared.
    drive(2'b01, 9'h055, 9'h000, 2'b00, 1'b0);
    #1 chk("mr_acc0_ready", 32'(req_ready), 32'b01);
    cyc();
    drive(2'b00, 9'h000, 9'h000, 2'b00, 1'b0);
    #1 chk("mr_done0", 32'(req_done), 32'b01);
    cyc();
    drive(2'b11, 9'h0C3, 9'h155, 2'b00, 1'b0);
    #1 chk("mr_acc1_ready", 32'(req_ready), 32'b10);
    cyc();
    drive(2'b00, 9'h0C3, 9'h155, 2'b00, 1'b1);
    #1 chk("mr_write_pre", 32'(write), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_write", 32'(write), 32'd0);
    chk("mr_cs", 32'(chipselect), 32'd0);
    chk("mr_wd", 32'(writedata), 32'd0);
    chk("mr_addr", 32'(address), 32'd0);
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_done", 32'(req_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'b11, 9'h0C3, 9'h155, 2'b00, 1'b0);
    #1 chk("mr_first_ready", 32'(req_ready), 32'b01);
    cyc();
    drive(2'b00, 9'h0C3, 9'h155, 2'b00, 1'b0);
    #1;
    chk("mr_first_done", 32'(req_done), 32'b01);
    chk("mr_first_wd", 32'(writedata), 32'hC3);
    cyc();

    // Requester 1 streams 16 words with lock held while requester 0 waits.
    n1 = 0;
    for (int k = 0; k < 16; k++) begin
`ifdef LCD_ARB_LOCK_EN
      exp_own = 2'b10;
`else
      exp_own = (k % 2 == 0) ? 2'b10 : 2'b01;
`endif
      exp_wd = (exp_own == 2'b10) ? 8'(8'h40 + n1) : 8'hC3;
      drive(2'b11, 9'h0C3, 9'(9'h040 + n1), 2'b10, 1'b0);
      #1 chk($sformatf("lk%0d_ready", k), 32'(req_ready), 32'(exp_own));
      cyc();
      #1;
      chk($sformatf("lk%0d_grant", k), 32'(grant), 32'(exp_own));
      chk($sformatf("lk%0d_write", k), 32'(write), 32'd1);
      chk($sformatf("lk%0d_wd", k), 32'(writedata), 32'(exp_wd));
      chk($sformatf("lk%0d_done", k), 32'(req_done), 32'(exp_own));
      if (exp_own == 2'b10) n1++;
      cyc();
    end

`ifdef LCD_ARB_LOCK_EN
    drive(2'b01, 9'h0C3, 9'h000, 2'b10, 1'b0);
    #1;
    chk("lkhold_ready", 32'(req_ready), 32'b00);
    chk("lkhold_grant", 32'(grant), 32'b10);
    cyc();
    drive(2'b01, 9'h0C3, 9'h000, 2'b00, 1'b0);
    #1;
    chk("lkrel_ready", 32'(req_ready), 32'b00);
    chk("lkrel_grant", 32'(grant), 32'b10);
    cyc();
    #1;
    chk("lkpost_ready", 32'(req_ready), 32'b01);
    chk("lkpost_grant", 32'(grant), 32'b00);
    cyc();
    #1;
    chk("lkpost_done", 32'(req_done), 32'b01);
    chk("lkpost_wd", 32'(writedata), 32'hC3);
    cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
